piso_shift_tx: RTL and testbench

Parameterised parallel-in/serial-out shift transmitter. It accepts an N-bit word through a valid/ready load handshake and shifts the word out MSB-first, one bit per `en` strobe. It is the transmit end of the team's serial-in/parallel-out shift chain. That chain uses the same `en` strobe and shifts each new bit in toward the oldest position, so after N strobes its `parallel_out` equals the loaded word bit-for-bit. It sits between a word-wide producer (FSM or FIFO) and the single-wire serial link.

---
 rtl/piso_shift_tx.sv | 121 ++++++++++++
 tb/tb_piso_shift_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
//
// Parallel-in / serial-out shift transmitter. A word of N bits is accepted
// through a valid/ready load handshake and shifted out MSB-first, one bit
// per `en` strobe. Bits leave in the order a matching serial-in/parallel-out
// chain driven by the same `en` needs, so that chain's parallel output
// equals the loaded word once the frame is complete.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active low
//   clr         in   synchronous clear, active high; dominates load and en
//   en          in   shift strobe; one bit consumed per high cycle in a frame
//   load_valid  in   producer offers `data_in`
//   load_ready  out  transmitter can take a word this cycle
//   data_in     in   [N-1:0] word, sampled only on a handshake
//   serial_out  out  current bit (registered, always sr[N-1])
//   frame       out  high while serial_out carries a valid bit
//   done        out  one-cycle pulse after the last bit of a frame is consumed
//   fsm_state   out  debug view of the FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word is transferred on a rising edge where load_valid and
// load_ready are both high. load_valid may be raised at any time and the
// producer holds data_in until the transfer edge; load_ready never depends
// on load_valid. load_ready is high in IDLE, and also in SHIFT during the
// cycle whose `en` consumes the last bit, which lets the next word follow
// with no gap bit.
// -----------------------------------------------------------------------------
module piso_shift_tx #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] data_in,
  output logic         serial_out,
  output logic         frame,
  output logic         done,
  output logic [0:0]   fsm_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]   state;
  logic [N-1:0] sr;
  logic [CW-1:0] cnt;
  logic         last_bit;
  logic         load_fire;

  // The en strobe of the final bit of the current frame.
  assign last_bit   = (state == SHIFT) && (cnt == LAST) && en;
  assign load_ready = (state == IDLE) || last_bit;
  assign load_fire  = load_valid && load_ready;

  assign serial_out = sr[N-1];
  assign frame      = (state == SHIFT);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (clr) begin
      // Abort: any frame in progress is dropped without a done pulse and a
      // coincident handshake is discarded.
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // en is ignored while idle.
          if (load_fire) begin
            sr    <= data_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            if (cnt == LAST) begin
              done <= 1'b1;
              if (load_fire) begin
                // Back-to-back: next word's MSB appears right after the
                // last bit of this one.
                sr  <= data_in;
                cnt <= '0;
              end else begin
                sr    <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end else begin
              // A plain shift keeps N=1 legal (the result is simply zero).
              sr  <= sr << 1;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          sr    <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
module tb_piso_shift_tx;

  logic       clk;
  logic       rst;
  logic       clr;

  // N = 8 instance
  logic       en;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] data_in;
  logic       serial_out;
  logic       frame;
  logic       done;
  logic [0:0] fsm_state;

  // N = 1 instance
  logic       en1;
  logic       load_valid1;
  logic       load_ready1;
  logic [0:0] data_in1;
  logic       serial_out1;
  logic       frame1;
  logic       done1;
  logic [0:0] fsm_state1;

  // Receiver model: 8-stage SIPO on the same en strobe.
  logic [7:0] sipo;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_tx #(.N(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .serial_out (serial_out),
    .frame      (frame),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  piso_shift_tx #(.N(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (en1),
    .load_valid (load_valid1),
    .load_ready (load_ready1),
    .data_in    (data_in1),
    .serial_out (serial_out1),
    .frame      (frame1),
    .done       (done1),
    .fsm_state  (fsm_state1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst)    sipo <= 8'h00;
    else if (en) sipo <= {sipo[6:0], serial_out};
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle8(input string tag);
    check({tag, ".so"},    serial_out, 0);
    check({tag, ".frame"}, frame,      0);
    check({tag, ".done"},  done,       0);
    check({tag, ".ready"}, load_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] w;

    rst = 1'b0; clr = 1'b0; en = 1'b0; load_valid = 1'b0; data_in = 8'h00;
    en1 = 1'b0; load_valid1 = 1'b0; data_in1 = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      clr         = 1'($urandom_range(0, 1));
      en          = 1'($urandom_range(0, 1));
      load_valid  = 1'($urandom_range(0, 1));
      data_in     = 8'($urandom_range(0, 255));
      en1         = 1'($urandom_range(0, 1));
      load_valid1 = 1'($urandom_range(0, 1));
      data_in1    = 1'($urandom_range(0, 1));
      tick();
      check_idle8("reset");
      check("reset.state", fsm_state, 0);
      check("reset.so1", serial_out1, 0);
      check("reset.frame1", frame1, 0);
      check("reset.done1", done1, 0);
      check("reset.ready1", load_ready1, 1);
    end
    clr = 0; en = 0; load_valid = 0; data_in = 0;
    en1 = 0; load_valid1 = 0; data_in1 = 0;
    rst = 1'b1;
    tick();
    check_idle8("post_reset");

    // ---- 0xA5, en continuous ----
    w = 8'hA5;
    load_valid = 1; data_in = w; en = 1;
    #1 check("a5.ready_idle", load_ready, 1);
    tick();
    load_valid = 0; data_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("a5.so[%0d]", k), serial_out, w[7-k]);
      check($sformatf("a5.frame[%0d]", k), frame, 1);
      check($sformatf("a5.done[%0d]", k), done, 0);
      check($sformatf("a5.ready[%0d]", k), load_ready, (k == 7));
      tick();
    end
    check("a5.done_pulse", done, 1);
    check("a5.frame_end", frame, 0);
    check("a5.so_end", serial_out, 0);
    check("a5.sipo", sipo, 8'hA5);
    en = 0;
    tick();
    check_idle8("a5.after");

    // ---- 0x3C, en every third cycle; mid-frame load attempt refused ----
    w = 8'h3C;
    load_valid = 1; data_in = w; en = 0;
    tick();
    load_valid = 0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < 3; g++) begin
        en         = (g == 2);
        load_valid = (k == 3);
        data_in    = (k == 3) ? 8'hFF : 8'h00;
        #1;
        check($sformatf("3c.so[%0d.%0d]", k, g), serial_out, w[7-k]);
        check($sformatf("3c.frame[%0d.%0d]", k, g), frame, 1);
        check($sformatf("3c.done[%0d.%0d]", k, g), done, 0);
        check($sformatf("3c.ready[%0d.%0d]", k, g), load_ready, (k == 7 && g == 2));
        tick();
      end
    end
    en = 0; load_valid = 0; data_in = 0;
    check("3c.done_pulse", done, 1);
    check("3c.frame_end", frame, 0);
    check("3c.sipo", sipo, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("3c.done_once", done, 0);
      check("3c.stay_idle", frame, 0);
    end

    // ---- back-to-back 0xFF then 0x00 ----
    load_valid = 1; data_in = 8'hFF; en = 1;
    tick();
    data_in = 8'h00;
    for (int c = 0; c < 16; c++) begin
      load_valid = (c < 8);
      #1;
      check($sformatf("b2b.frame[%0d]", c), frame, 1);
      check($sformatf("b2b.so[%0d]", c), serial_out, (c < 8));
      check($sformatf("b2b.done[%0d]", c), done, (c == 8));
      check($sformatf("b2b.ready[%0d]", c), load_ready, (c == 7 || c == 15));
      tick();
    end
    load_valid = 0;
    check("b2b.done_end", done, 1);
    check("b2b.frame_end", frame, 0);
    en = 0;
    tick();
    check_idle8("b2b.after");

    // ---- abort with clr after 3 bits, coincident load ----
    w = 8'hA5;
    load_valid = 1; data_in = w; en = 1;
    tick();
    load_valid = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort.so[%0d]", k), serial_out, w[7-k]);
      tick();
    end
    check("abort.so[3]", serial_out, w[4]);
    clr = 1; load_valid = 1; data_in = 8'h5A;
    tick();
    clr = 0; load_valid = 0; en = 0; data_in = 0;
    #1;
    check_idle8("abort.next");
    check("abort.state", fsm_state, 0);
    tick();
    check("abort.no_done", done, 0);
    check("abort.discarded", frame, 0);

    // ---- asynchronous reset mid-frame ----
    load_valid = 1; data_in = 8'hC3; en = 1;
    tick();
    load_valid = 0;
    check("arst.frame_before", frame, 1);
    check("arst.so_before", serial_out, 1);
    #2 rst = 0;
    #1;
    check_idle8("arst.async");
    #2 rst = 1;
    en = 0;
    tick();
    check_idle8("arst.after");

    // ---- N=1 back-to-back 1 then 0 ----
    load_valid1 = 1; data_in1 = 1'b1; en1 = 1;
    #1 check("n1.ready_idle", load_ready1, 1);
    tick();
    check("n1.so0", serial_out1, 1);
    check("n1.frame0", frame1, 1);
    check("n1.done0", done1, 0);
    data_in1 = 1'b0;
    #1 check("n1.ready_last", load_ready1, 1);
    tick();
    load_valid1 = 0;
    check("n1.so1", serial_out1, 0);
    check("n1.frame1", frame1, 1);
    check("n1.done1", done1, 1);
    tick();
    check("n1.frame_end", frame1, 0);
    check("n1.done2", done1, 1);
    check("n1.so_end", serial_out1, 0);
    en1 = 0;
    tick();
    check("n1.done_clear", done1, 0);
    check("n1.ready_end", load_ready1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
